// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch control states
//   fetch_entry_t : {instruction, pc} payload carried through the skid buffer
package fetch_pkg;

  localparam int unsigned PC_W   = 8;
  localparam int unsigned INST_W = 10;
  localparam int unsigned OFF_W  = 7;

  localparam logic [PC_W-1:0] START_ADDR_DFLT = PC_W'(0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus: ROM port plus the valid/ready handshake towards decode.
//   master : fetch unit side (drives RomAddr, Instruction, InstPC, InstValid)
//   slave  : ROM/decode side (drives RomData, InstReady, Branch, Offset, HaltReq)
interface inst_fetch_unit_if;
  import fetch_pkg::*;

  logic [PC_W-1:0]   RomAddr;
  logic [INST_W-1:0] RomData;
  logic [INST_W-1:0] Instruction;
  logic [PC_W-1:0]   InstPC;
  logic              InstValid;
  logic              InstReady;
  logic              Branch;
  logic [OFF_W-1:0]  Offset;
  logic              HaltReq;

  modport master (
    output RomAddr, Instruction, InstPC, InstValid,
    input  RomData, InstReady, Branch, Offset, HaltReq
  );

  modport slave (
    input  RomAddr, Instruction, InstPC, InstValid,
    output RomData, InstReady, Branch, Offset, HaltReq
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer for {instruction, pc}.
//   clk, rst_n          : clock, async active-low reset
//   flush               : drop the held entry
//   in_valid/in_ready_c : write side (in_ready_c is combinational)
//   out_valid/out_ready : read side, out_data is the held entry
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready_c,
  input  fetch_entry_t in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output fetch_entry_t out_data
);

  logic         valid_q, valid_d;
  fetch_entry_t data_q,  data_d;

  // Room when empty or when the held entry leaves this cycle.
  assign in_ready_c = !valid_q || out_ready;
  assign out_valid  = valid_q;
  assign out_data   = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (in_valid && in_ready_c) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end
    if (flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, synchronous ROM addressing, registered output
// to decode with valid/ready, one-entry skid, branch redirect, halt, and
// saturating count of accepted instructions.
//   CLK, RST_N : clock, async active-low reset
//   Init       : restart fetch at START_ADDR
//   bus        : ROM port and decode handshake (master side)
//   Halted     : fetch stopped after an accepted halt
//   InstCount  : accepted instruction count (saturating)
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] START_ADDR = START_ADDR_DFLT,
  parameter int unsigned     CNT_W      = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  Init,
  inst_fetch_unit_if.master     bus,
  output logic                  Halted,
  output logic [CNT_W-1:0]      InstCount
);

  fetch_state_t      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [PC_W-1:0]   inflight_pc_q, inflight_pc_d;
  fetch_entry_t      out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept, do_halt, do_branch, flush, out_free, issue;
  logic [2:0]        occ_next;
  logic [PC_W-1:0]   br_target;
  fetch_entry_t      rom_entry;
  logic              skid_in_valid, skid_in_ready_c, skid_valid;
  fetch_entry_t      skid_data;

  fetch_skid_buf u_skid (
    .clk        (CLK),
    .rst_n      (RST_N),
    .flush      (flush),
    .in_valid   (skid_in_valid),
    .in_ready_c (skid_in_ready_c),
    .in_data    (rom_entry),
    .out_valid  (skid_valid),
    .out_ready  (out_free),
    .out_data   (skid_data)
  );

  assign bus.RomAddr     = pc_q;
  assign bus.Instruction = out_q.inst;
  assign bus.InstPC      = out_q.pc;
  assign bus.InstValid   = out_valid_q;
  assign Halted          = halted_q;
  assign InstCount       = cnt_q;

  // Next-state, datapath and control.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    out_d         = out_q;
    out_valid_d   = out_valid_q;
    cnt_d         = cnt_q;

    // Init beats halt, halt beats branch.
    accept    = out_valid_q && bus.InstReady;
    do_halt   = accept && bus.HaltReq && !Init;
    do_branch = accept && bus.Branch && !bus.HaltReq && !Init;
    flush     = Init || do_halt || do_branch;
    out_free  = !out_valid_q || accept;
    br_target = out_q.pc + {{(PC_W-OFF_W){bus.Offset[OFF_W-1]}}, bus.Offset};
    rom_entry = '{inst: bus.RomData, pc: inflight_pc_q};

    // Issue only if next cycle still has a free slot for the returning word,
    // even when decode stalls; this bounds the skid at one entry.
    occ_next = 3'(out_valid_q) + 3'(skid_valid) + 3'(inflight_q) - 3'(accept);
    issue    = (state_q == RUN) && (occ_next < 3'd2);

    // Returning ROM word goes to the skid unless the output slot takes it.
    skid_in_valid = inflight_q && (skid_valid || !out_free);

    if (out_free) begin
      if (skid_valid) begin
        out_d       = skid_data;
        out_valid_d = 1'b1;
      end else if (inflight_q) begin
        out_d       = rom_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    if (issue) begin
      pc_d          = pc_q + PC_W'(1);
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end

    if (accept && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (do_branch) begin
      pc_d        = br_target;
      inflight_d  = 1'b0;
      out_valid_d = 1'b0;
    end

    if (do_halt) begin
      state_d     = HALTED;
      pc_d        = pc_q;
      inflight_d  = 1'b0;
      out_valid_d = 1'b0;
    end

    if (Init) begin
      state_d     = RUN;
      pc_d        = START_ADDR;
      inflight_d  = 1'b0;
      out_d       = '0;
      out_valid_d = 1'b0;
      cnt_d       = '0;
    end

    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      out_q         <= '0;
      out_valid_q   <= 1'b0;
      halted_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      out_q         <= out_d;
      out_valid_q   <= out_valid_d;
      halted_q      <= halted_d;
      cnt_q         <= cnt_d;
    end
  end

  // A returning word must always find room.
  assert property (@(posedge CLK) disable iff (!RST_N)
                   skid_in_valid |-> skid_in_ready_c);

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;
  import fetch_pkg::*;

  logic        CLK;
  logic        RST_N;
  logic        Init;
  logic        Halted;
  logic [15:0] InstCount;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  inst_fetch_unit_if bus();

  inst_fetch_unit dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .Init      (Init),
    .bus       (bus.master),
    .Halted    (Halted),
    .InstCount (InstCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Registered ROM with ROM[i] = i.
  always @(posedge CLK) bus.RomData <= INST_W'(bus.RomAddr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_inst(input string tag, input logic [7:0] pc);
    chk({tag, "_valid"}, 32'(bus.InstValid), 32'd1);
    chk({tag, "_pc"},    32'(bus.InstPC), 32'(pc));
    chk({tag, "_inst"},  32'(bus.Instruction), 32'(pc));
    chk({tag, "_cnt"},   32'(InstCount), 32'(exp_cnt));
  endtask

  // Previous cycle's instruction is accepted; the next one must follow.
  task automatic advance(input logic [7:0] pc);
    step();
    exp_cnt++;
    expect_inst("stream", pc);
  endtask

  task automatic take_branch(input logic [6:0] off, input logic [7:0] target);
    bus.Branch = 1'b1;
    bus.Offset = off;
    step();
    exp_cnt++;
    bus.Branch = 1'b0;
    bus.Offset = '0;
    chk("br_gap1", 32'(bus.InstValid), 32'd0);
    step();
    chk("br_gap2", 32'(bus.InstValid), 32'd0);
    step();
    expect_inst("br_tgt", target);
  endtask

  initial begin
    RST_N         = 1'b0;
    Init          = 1'b0;
    bus.InstReady = 1'b0;
    bus.Branch    = 1'b0;
    bus.Offset    = '0;
    bus.HaltReq   = 1'b0;

    step();
    step();
    chk("rst_romaddr", 32'(bus.RomAddr), 32'd0);
    chk("rst_valid",   32'(bus.InstValid), 32'd0);
    chk("rst_inst",    32'(bus.Instruction), 32'd0);
    chk("rst_pc",      32'(bus.InstPC), 32'd0);
    chk("rst_cnt",     32'(InstCount), 32'd0);
    chk("rst_halted",  32'(Halted), 32'd0);

    RST_N = 1'b1;
    step();
    step();
    chk("idle_valid",   32'(bus.InstValid), 32'd0);
    chk("idle_romaddr", 32'(bus.RomAddr), 32'd0);

    // Init and start-up latency.
    bus.InstReady = 1'b1;
    Init = 1'b1;
    step();
    Init = 1'b0;
    chk("lat_c1_romaddr", 32'(bus.RomAddr), 32'd0);
    chk("lat_c1_valid",   32'(bus.InstValid), 32'd0);
    step();
    chk("lat_c2_valid",   32'(bus.InstValid), 32'd0);
    step();
    exp_cnt = 0;
    expect_inst("lat_c3", 8'h00);
    for (int p = 1; p <= 5; p++) advance(8'(p));

    // Back-pressure at InstPC=5 for four cycles.
    bus.InstReady = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      expect_inst("stall", 8'h05);
      chk("stall_romaddr", 32'(bus.RomAddr), 32'h07);
    end
    bus.InstReady = 1'b1;
    advance(8'h06);
    advance(8'h07);
    for (int p = 8; p <= 16; p++) advance(8'(p));

    // Branches: backward, into the top of the space, wrapping, and loop.
    take_branch(7'h7D, 8'h0D);
    take_branch(7'h71, 8'hFE);
    take_branch(7'h05, 8'h03);
    take_branch(7'h7A, 8'hFD);
    advance(8'hFE);
    advance(8'hFF);
    advance(8'h00);
    advance(8'h01);
    take_branch(7'h00, 8'h01);

    // Init together with Branch: Init wins.
    Init = 1'b1;
    bus.Branch = 1'b1;
    bus.Offset = 7'h10;
    step();
    Init = 1'b0;
    bus.Branch = 1'b0;
    bus.Offset = '0;
    exp_cnt = 0;
    chk("initbr_cnt",     32'(InstCount), 32'd0);
    chk("initbr_valid",   32'(bus.InstValid), 32'd0);
    chk("initbr_romaddr", 32'(bus.RomAddr), 32'd0);
    step();
    chk("initbr_gap", 32'(bus.InstValid), 32'd0);
    step();
    expect_inst("initbr_tgt", 8'h00);
    for (int p = 1; p <= 32; p++) advance(8'(p));

    // Halt at InstPC=0x20.
    bus.HaltReq = 1'b1;
    step();
    bus.HaltReq = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("halt_halted",  32'(Halted), 32'd1);
      chk("halt_valid",   32'(bus.InstValid), 32'd0);
      chk("halt_cnt",     32'(InstCount), 32'h21);
      chk("halt_romaddr", 32'(bus.RomAddr), 32'h22);
      step();
    end

    // Init leaves HALTED.
    Init = 1'b1;
    step();
    Init = 1'b0;
    exp_cnt = 0;
    chk("rehalt_halted", 32'(Halted), 32'd0);
    chk("rehalt_cnt",    32'(InstCount), 32'd0);
    step();
    step();
    expect_inst("restart", 8'h00);
    advance(8'h01);
    advance(8'h02);

    // HaltReq together with Branch: halt wins.
    bus.HaltReq = 1'b1;
    bus.Branch  = 1'b1;
    bus.Offset  = 7'h05;
    step();
    bus.HaltReq = 1'b0;
    bus.Branch  = 1'b0;
    bus.Offset  = '0;
    for (int k = 0; k < 2; k++) begin
      chk("hb_halted",  32'(Halted), 32'd1);
      chk("hb_valid",   32'(bus.InstValid), 32'd0);
      chk("hb_cnt",     32'(InstCount), 32'd3);
      chk("hb_romaddr", 32'(bus.RomAddr), 32'h04);
      step();
    end

    // Restart, stall, then asynchronous reset mid-cycle.
    Init = 1'b1;
    step();
    Init = 1'b0;
    exp_cnt = 0;
    step();
    step();
    expect_inst("pre_rst", 8'h00);
    advance(8'h01);
    advance(8'h02);
    advance(8'h03);
    bus.InstReady = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_romaddr", 32'(bus.RomAddr), 32'd0);
    chk("arst_valid",   32'(bus.InstValid), 32'd0);
    chk("arst_inst",    32'(bus.Instruction), 32'd0);
    chk("arst_pc",      32'(bus.InstPC), 32'd0);
    chk("arst_cnt",     32'(InstCount), 32'd0);
    chk("arst_halted",  32'(Halted), 32'd0);
    #2;
    RST_N = 1'b1;
    bus.InstReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("postrst_valid",   32'(bus.InstValid), 32'd0);
      chk("postrst_romaddr", 32'(bus.RomAddr), 32'd0);
      chk("postrst_cnt",     32'(InstCount), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
